lsu_mem_port: RTL and testbench

Load/store unit memory port: it is the initiator that drives the simulation memory responder's `re/we/len/addr/wdata/rdata` port. It accepts one load or store per transaction from the execute stage over a valid/ready handshake, checks alignment, and issues a timed memory access with a configurable latency. It sign- or zero-extends load data and returns the result over a second valid/ready handshake. It sits between EXU and the DPI-backed RAM.

---
 rtl/lsu_mem_port_pkg.sv | 42 ++++
 rtl/lsu_mem_port_if.sv | 44 ++++
 rtl/lsu_mem_port_load_ext.sv | 30 +++
 rtl/lsu_mem_port.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared encodings and helpers for the load/store unit memory port.
// Size codes, FSM state type, and the alignment/length rules used at request time.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } lsu_state_e;

    function automatic logic [7:0] len_of(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'd1;
            SZ_H:    return 8'd2;
            SZ_W:    return 8'd4;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Store data keeps only the bytes the access actually writes.
    function automatic logic [31:0] store_mask(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_B:    return {24'd0, data[7:0]};
            SZ_H:    return {16'd0, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Bus bundles for the LSU: request/response handshake toward EXU and the
// re/we/len/addr/wdata/rdata port toward the memory responder.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_re, mem_we, mem_len, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_re, mem_we, mem_len, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port_load_ext.sv
// Load data extension: keeps only the accessed bytes, then sign- or zero-extends.
// Purely combinational so a future cached LSU can reuse it on its hit path.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] ext_o
);

    logic sign;

    always_comb begin
        sign  = 1'b0;
        ext_o = data_i;
        case (size_i)
            SZ_B: begin
                sign  = data_i[7] & ~unsigned_i;
                ext_o = {{24{sign}}, data_i[7:0]};
            end
            SZ_H: begin
                sign  = data_i[15] & ~unsigned_i;
                ext_o = {{16{sign}}, data_i[15:0]};
            end
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one transaction at a time from EXU, timed access
// of LAT cycles to the memory responder, extended load data returned to EXU.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    lsu_req_if.slave        req_if,
    lsu_mem_if.master       mem_if
);

    localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

    lsu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [7:0]  len_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] ext;
    logic        last;
    logic        req_bad;
    logic        accept;
    logic        retire;

    assign last    = (cnt_q == LAST_CNT);
    assign req_bad = (req_if.req_size == 2'd3)
                   || misaligned(req_if.req_size, req_if.req_addr[1:0]);
    assign accept  = (state_q == ST_IDLE) && req_if.req_valid && !req_bad;
    assign retire  = ((state_q == ST_RESP) || (state_q == ST_ERR)) && req_if.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    state_d = req_bad ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (last) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP, ST_ERR: begin
                if (req_if.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Store strobes only on the first access cycle so a write is never repeated.
    always_comb begin
        req_if.req_ready = 1'b0;
        req_if.rsp_valid = 1'b0;
        req_if.rsp_err   = 1'b0;
        mem_if.mem_re    = 1'b0;
        mem_if.mem_we    = 1'b0;
        case (state_q)
            ST_IDLE:   req_if.req_ready = 1'b1;
            ST_ACCESS: begin
                mem_if.mem_re = ~we_q;
                mem_if.mem_we = we_q && (cnt_q == 4'd0);
            end
            ST_RESP:   req_if.rsp_valid = 1'b1;
            ST_ERR: begin
                req_if.rsp_valid = 1'b1;
                req_if.rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = 4'd0;
        if ((state_q == ST_ACCESS) && !last) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Request latch; the memory-facing fields read as zero outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            len_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= req_if.req_we;
            uns_q   <= req_if.req_unsigned;
            size_q  <= req_if.req_size;
            len_q   <= len_of(req_if.req_size);
            addr_q  <= req_if.req_addr;
            wdata_q <= store_mask(req_if.req_size, req_if.req_wdata);
        end else if ((state_q == ST_ACCESS) && last) begin
            len_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end
    end

    lsu_load_ext u_load_ext (
        .data_i     (mem_if.mem_rdata),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .ext_o      (ext)
    );

    // Load data is sampled on the final access cycle; stores and errors report zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if ((state_q == ST_ACCESS) && last) begin
            rdata_q <= we_q ? 32'd0 : ext;
        end else if (retire) begin
            rdata_q <= 32'd0;
        end
    end

    assign req_if.rsp_rdata = rdata_q;
    assign mem_if.mem_len   = len_q;
    assign mem_if.mem_addr  = addr_q;
    assign mem_if.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: three instances (LAT=1,3,4) share one stimulus
// driver, a byte-array memory responder and a scoreboard of expected responses.
module tb_lsu_mem_port;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int          sel;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    lsu_req_if r1 (); lsu_req_if r3 (); lsu_req_if r4 ();
    lsu_mem_if m1 (); lsu_mem_if m3 (); lsu_mem_if m4 ();

    assign r1.req_valid = req_valid && (sel == 1);
    assign r3.req_valid = req_valid && (sel == 3);
    assign r4.req_valid = req_valid && (sel == 4);
    assign r1.rsp_ready = rsp_ready && (sel == 1);
    assign r3.rsp_ready = rsp_ready && (sel == 3);
    assign r4.rsp_ready = rsp_ready && (sel == 4);
    assign r1.req_we = req_we; assign r3.req_we = req_we; assign r4.req_we = req_we;
    assign r1.req_size = req_size; assign r3.req_size = req_size; assign r4.req_size = req_size;
    assign r1.req_unsigned = req_unsigned; assign r3.req_unsigned = req_unsigned;
    assign r4.req_unsigned = req_unsigned;
    assign r1.req_addr = req_addr; assign r3.req_addr = req_addr; assign r4.req_addr = req_addr;
    assign r1.req_wdata = req_wdata; assign r3.req_wdata = req_wdata; assign r4.req_wdata = req_wdata;

    lsu_mem_port #(.LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .req_if(r1), .mem_if(m1));
    lsu_mem_port #(.LAT(3)) u_lat3 (.clk(clk), .rst_n(rst_n), .req_if(r3), .mem_if(m3));
    lsu_mem_port #(.LAT(4)) u_lat4 (.clk(clk), .rst_n(rst_n), .req_if(r4), .mem_if(m4));

    // Memory responder: right-aligned data with 0xA5 garbage above the access length.
    logic [7:0] mem_b [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr, pl_data;

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [7:0] l);
        logic [7:0]  b;
        logic [31:0] w;
        b = a[7:0];
        w = {mem_b[b + 8'd3], mem_b[b + 8'd2], mem_b[b + 8'd1], mem_b[b]};
        case (l)
            8'd1:    return {24'hA5A5A5, w[7:0]};
            8'd2:    return {16'hA5A5, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign m1.mem_rdata = mem_rd(m1.mem_addr, m1.mem_len);
    assign m3.mem_rdata = mem_rd(m3.mem_addr, m3.mem_len);
    assign m4.mem_rdata = mem_rd(m4.mem_addr, m4.mem_len);

    logic        req_ready, rsp_valid, rsp_err, mx_re, mx_we;
    logic [31:0] rsp_rdata, mx_addr, mx_wdata;
    logic [7:0]  mx_len;

    always_comb begin
        req_ready = r4.req_ready; rsp_valid = r4.rsp_valid; rsp_err = r4.rsp_err;
        rsp_rdata = r4.rsp_rdata; mx_re = m4.mem_re; mx_we = m4.mem_we;
        mx_len = m4.mem_len; mx_addr = m4.mem_addr; mx_wdata = m4.mem_wdata;
        if (sel == 1) begin
            req_ready = r1.req_ready; rsp_valid = r1.rsp_valid; rsp_err = r1.rsp_err;
            rsp_rdata = r1.rsp_rdata; mx_re = m1.mem_re; mx_we = m1.mem_we;
            mx_len = m1.mem_len; mx_addr = m1.mem_addr; mx_wdata = m1.mem_wdata;
        end else if (sel == 3) begin
            req_ready = r3.req_ready; rsp_valid = r3.rsp_valid; rsp_err = r3.rsp_err;
            rsp_rdata = r3.rsp_rdata; mx_re = m3.mem_re; mx_we = m3.mem_we;
            mx_len = m3.mem_len; mx_addr = m3.mem_addr; mx_wdata = m3.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (pl_en) mem_b[pl_addr] <= pl_data;
        if (mx_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(mx_len)) mem_b[mx_addr[7:0] + 8'(i)] <= mx_wdata[8*i +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          re_cnt = 0, we_cnt = 0;
    logic [7:0]  re_len, we_len;
    logic [31:0] we_wdata;
    always @(negedge clk) begin
        if (mx_re) begin re_cnt <= re_cnt + 1; re_len <= mx_len; end
        if (mx_we) begin we_cnt <= we_cnt + 1; we_len <= mx_len; we_wdata <= mx_wdata; end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [7:0]  b, v;
        logic [15:0] h;
        b = a[7:0];
        case (sz)
            2'd0: begin v = mem_b[b]; return u ? {24'd0, v} : {{24{v[7]}}, v}; end
            2'd1: begin h = {mem_b[b + 8'd1], mem_b[b]}; return u ? {16'd0, h} : {{16{h[15]}}, h}; end
            default: return {mem_b[b + 8'd3], mem_b[b + 8'd2], mem_b[b + 8'd1], mem_b[b]};
        endcase
    endfunction

    task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
        exp_t        e;
        int          lat_cfg, t0, re0, we0;
        bit          got;
        logic [31:0] h_rd;
        logic [31:0] exp_wd;
        lat_cfg = (sel == 1) ? 1 : (sel == 3) ? 3 : 4;
        e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        e.rdata = (e.err || we) ? 32'd0 : exp_load(a, sz, u);
        e.lat   = e.err ? 1 : lat_cfg + 1;
        exp_wd  = (sz == 2'd0) ? {24'd0, wd[7:0]} : (sz == 2'd1) ? {16'd0, wd[15:0]} : wd;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        re0 = re_cnt; we0 = we_cnt;
        @(posedge clk);
        #1;
        t0 = cyc;
        req_valid = 1'b0; req_we = ~we; req_size = 2'd2; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, ".rsp_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, ".latency"}, 32'(cyc - t0 + 1), 32'(e.lat));
        h_rd = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata, h_rd);
            chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        chk({tag, ".rdata"}, rsp_rdata, e.rdata);
        chk({tag, ".err"}, 32'(rsp_err), 32'(e.err));
        chk({tag, ".retire_req_ready"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0004;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, ".after_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".after_req_ready"}, 32'(req_ready), 32'd1);
        if (hold > 0) begin
            chk({tag, ".no_overlap_accept"}, 32'(mx_re), 32'd0);
            req_valid = 1'b0;
        end
        chk({tag, ".re_cycles"}, 32'(re_cnt - re0), (!e.err && !we) ? 32'(lat_cfg) : 32'd0);
        chk({tag, ".we_pulses"}, 32'(we_cnt - we0), (!e.err && we) ? 32'd1 : 32'd0);
        if (!e.err && we) begin
            chk({tag, ".we_len"}, 32'(we_len), (sz == 2'd0) ? 32'd1 : (sz == 2'd1) ? 32'd2 : 32'd4);
            chk({tag, ".we_wdata"}, we_wdata, exp_wd);
        end
        if (!e.err && !we) begin
            chk({tag, ".re_len"}, 32'(re_len), (sz == 2'd0) ? 32'd1 : (sz == 2'd1) ? 32'd2 : 32'd4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nrsp;
        sel = 1; rst_n = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_err", 32'(rsp_err), 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'd0);
        chk("reset.mem_re_we", {30'd0, mx_re, mx_we}, 32'd0);
        chk("reset.mem_len", 32'(mx_len), 32'd0);
        chk("reset.mem_addr", mx_addr, 32'd0);
        chk("reset.mem_wdata", mx_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(8'h04, 8'hEF); preload(8'h05, 8'hBE); preload(8'h06, 8'hAD); preload(8'h07, 8'hDE);
        preload(8'h01, 8'h80);
        preload(8'h10, 8'h44); preload(8'h11, 8'h33); preload(8'h12, 8'h22); preload(8'h13, 8'h11);

        sel = 1;
        xact("l1_ldw", 1'b0, SZ_W, 1'b0, 32'h8000_0004, 32'd0, 0);
        xact("l1_stb", 1'b1, SZ_B, 1'b0, 32'h8000_0008, 32'hFFFF_FF77, 0);
        xact("l1_ldb", 1'b0, SZ_B, 1'b0, 32'h8000_0008, 32'd0, 0);

        sel = 3;
        xact("l3_ldb_s", 1'b0, SZ_B, 1'b0, 32'h8000_0001, 32'd0, 0);
        xact("l3_ldb_u", 1'b0, SZ_B, 1'b1, 32'h8000_0001, 32'd0, 0);
        xact("l3_sth", 1'b1, SZ_H, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 0);
        xact("l3_ldh_s", 1'b0, SZ_H, 1'b0, 32'h8000_0002, 32'd0, 0);
        xact("l3_ldh_u", 1'b0, SZ_H, 1'b1, 32'h8000_0006, 32'd0, 0);
        xact("l3_misw", 1'b0, SZ_W, 1'b0, 32'h8000_0002, 32'd0, 0);
        xact("l3_size3", 1'b0, 2'd3, 1'b0, 32'h8000_0004, 32'd0, 0);
        xact("l3_mish_st", 1'b1, SZ_H, 1'b0, 32'h8000_0001, 32'hCAFE_F00D, 0);
        xact("l3_bp", 1'b0, SZ_W, 1'b0, 32'h8000_0004, 32'd0, 5);
        xact("l3_after_bp", 1'b0, SZ_H, 1'b0, 32'h8000_0006, 32'd0, 0);

        // Reset asserted in the second access cycle of a LAT=4 load.
        sel = 4;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0; req_addr = 32'h8000_0010;
        chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.mem_re_before", 32'(mx_re), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.mem_re", 32'(mx_re), 32'd0);
        chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid.mem_len", 32'(mx_len), 32'd0);
        chk("rst_mid.mem_addr", mx_addr, 32'd0);
        chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || mx_re) nrsp++;
        end
        chk("rst_mid.no_rsp", 32'(nrsp), 32'd0);
        xact("l4_fresh", 1'b0, SZ_W, 1'b0, 32'h8000_0010, 32'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
